// File: rtl/aes_pkg.sv
// ============================================================
// aes_pkg : shared AES widths, FSM encoding and byte-slice helper
// Revision: 1.0
// ============================================================
`default_nettype none

package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int BYTE_W      = 8;
  localparam int NUM_BYTES   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_fsm_e;

  // Byte 0 sits at the MSB of the block, so byte i starts at bit 120-8i.
  function automatic logic [6:0] byte_lsb(input logic [3:0] idx);
    return 7'(AES_BLOCK_W - BYTE_W * (int'(idx) + 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/sbox.sv
// ============================================================
// sbox : combinational AES forward S-box lookup
// Revision: 1.0
// ============================================================
`default_nettype none

module sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // Entry 0 occupies the top byte of the table.
  localparam logic [2047:0] c_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] w_lsb;

  assign w_lsb  = 11'd2040 - {i_byte, 3'b000};
  assign o_byte = c_SBOX[w_lsb +: 8];

endmodule

`default_nettype wire

// File: rtl/sub_bytes_seq.sv
// ============================================================
// sub_bytes_seq : iterative AES SubBytes, NUM_SBOX bytes per beat
// Revision: 1.0
// ============================================================
`default_nettype none

module sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int NUM_SBOX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int BEATS   = NUM_BYTES / NUM_SBOX;
  localparam int c_CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  generate
    if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4 ||
          NUM_SBOX == 8 || NUM_SBOX == 16)) begin : g_bad_num_sbox
      $error("sub_bytes_seq: NUM_SBOX must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  aes_fsm_e                  r_fsm;
  logic [c_CNT_W-1:0]        r_cnt;
  logic [AES_BLOCK_W-1:0]    r_state;

  logic [3:0]                w_idx    [NUM_SBOX];
  logic [BYTE_W-1:0]         w_sb_in  [NUM_SBOX];
  logic [BYTE_W-1:0]         w_sb_out [NUM_SBOX];
  logic [AES_BLOCK_W-1:0]    w_sub_state;
  logic                      w_last;
  logic                      w_accept;

  generate
    for (genvar k = 0; k < NUM_SBOX; k++) begin : g_sbox
      assign w_idx[k]   = 4'(int'(r_cnt) * NUM_SBOX + k);
      assign w_sb_in[k] = r_state[byte_lsb(w_idx[k]) +: BYTE_W];

      sbox u_sbox (
        .i_byte (w_sb_in[k]),
        .o_byte (w_sb_out[k])
      );
    end
  endgenerate

  always_comb begin
    w_sub_state = r_state;
    for (int k = 0; k < NUM_SBOX; k++) begin
      w_sub_state[byte_lsb(w_idx[k]) +: BYTE_W] = w_sb_out[k];
    end
  end

  assign w_last    = (r_cnt == c_CNT_W'(BEATS - 1));
  // A finished block can hand off and take the next one on the same edge.
  assign in_ready  = (r_fsm == IDLE) || ((r_fsm == DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_fsm == DONE);
  assign busy      = (r_fsm != IDLE);
  assign out_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm   <= IDLE;
      r_cnt   <= '0;
      r_state <= '0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (w_accept) begin
            r_state <= in_state;
            r_cnt   <= '0;
            r_fsm   <= RUN;
          end
        end
        RUN: begin
          r_state <= w_sub_state;
          if (w_last) begin
            r_fsm <= DONE;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        DONE: begin
          if (w_accept) begin
            r_state <= in_state;
            r_cnt   <= '0;
            r_fsm   <= RUN;
          end else if (out_ready) begin
            r_fsm <= IDLE;
          end
        end
        default: begin
          r_fsm <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sub_bytes_seq.sv
// ============================================================
// tb_sub_bytes_seq : directed self-checking bench for sub_bytes_seq
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_sub_bytes_seq;

  localparam logic [127:0] c_FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] c_FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] c_RAMP_IN  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] c_RAMP_OUT = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] c_ZERO_OUT = {16{8'h63}};
  localparam int           c_TMO      = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  logic [3:0]   ev_in_valid;
  logic [3:0]   ev_in_ready;
  logic [127:0] ev_in_state;
  logic [3:0]   ev_out_valid;
  logic [3:0]   ev_out_ready;
  logic [127:0] ev_out_state [4];
  logic [3:0]   ev_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sub_bytes_seq #(.NUM_SBOX(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  // Extra instances cover the other legal NUM_SBOX values.
  generate
    for (genvar g = 0; g < 4; g++) begin : g_ev
      localparam int NS = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
      sub_bytes_seq #(.NUM_SBOX(NS)) u_ev (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (ev_in_valid[g]),
        .in_ready  (ev_in_ready[g]),
        .in_state  (ev_in_state),
        .out_valid (ev_out_valid[g]),
        .out_ready (ev_out_ready[g]),
        .out_state (ev_out_state[g]),
        .busy      (ev_busy[g])
      );
    end
  endgenerate

  function automatic int ev_ns(input int d);
    case (d)
      0:       return 1;
      1:       return 2;
      2:       return 8;
      default: return 16;
    endcase
  endfunction

  // Reference S-box built from GF(2^8) inversion plus the affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] b);
    logic [7:0] inv = 8'h00;
    for (int x = 1; x < 256; x++) begin
      if (gmul(b, 8'(x)) == 8'h01) inv = 8'(x);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_sub(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) begin
      r[127-8*i -: 8] = ref_sbox(v[127-8*i -: 8]);
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Latency counts edges from the accepting edge (inclusive) until out_valid is seen.
  task automatic send_block(input logic [127:0] v, output int lat);
    in_state = v;
    in_valid = 1'b1;
    lat      = 0;
    do begin
      step();
      lat++;
      in_valid = 1'b0;
    end while (!out_valid && lat < c_TMO);
    if (!out_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_block timeout: out_valid=%0b after %0d cycles, required 1", out_valid, lat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (out_state !== 128'h0) begin n_fail++; $display("FAIL reset_out_state: got %h want 0", out_state); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    for (int d = 0; d < 4; d++) begin
      n_checks++;
      if (ev_in_ready[d] !== 1'b1 || ev_out_valid[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_ev%0d: in_ready=%b out_valid=%b want 1/0", d, ev_in_ready[d], ev_out_valid[d]);
      end
    end
  endtask

  task automatic test_known_vector();
    int lat;
    out_ready = 1'b0;
    in_state  = c_FIPS_IN;
    in_valid  = 1'b1;
    lat       = 0;
    step();
    lat++;
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL known_run_flags: in_ready=%b busy=%b want 0/1", in_ready, busy);
    end
    while (!out_valid && lat < c_TMO) begin
      step();
      lat++;
    end
    n_checks++;
    if (lat != 5) begin n_fail++; $display("FAIL known_latency: got %0d want 5", lat); end
    n_checks++;
    if (out_state !== c_FIPS_OUT) begin n_fail++; $display("FAIL known_data: got %h want %h", out_state, c_FIPS_OUT); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL known_return_idle: out_valid=%b in_ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_ramp_params();
    int lat;
    int exp_lat;
    ev_in_state = c_RAMP_IN;
    for (int d = 0; d < 4; d++) begin
      ev_in_valid[d] = 1'b1;
      lat = 0;
      do begin
        step();
        lat++;
        ev_in_valid[d] = 1'b0;
      end while (!ev_out_valid[d] && lat < c_TMO);
      exp_lat = 16 / ev_ns(d) + 1;
      n_checks++;
      if (lat != exp_lat) begin
        n_fail++;
        $display("FAIL ramp_latency_ns%0d: got %0d want %0d", ev_ns(d), lat, exp_lat);
      end
      n_checks++;
      if (ev_out_state[d] !== c_RAMP_OUT) begin
        n_fail++;
        $display("FAIL ramp_data_ns%0d: got %h want %h", ev_ns(d), ev_out_state[d], c_RAMP_OUT);
      end
      ev_out_ready[d] = 1'b1;
      step();
      ev_out_ready[d] = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    send_block(128'h0, lat);
    // Offer a different state while stalled; it must be ignored.
    in_state = c_FIPS_IN;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_state !== c_ZERO_OUT || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold%0d: out_valid=%b in_ready=%b out_state=%h want 1/0/%h",
                 i, out_valid, in_ready, out_state, c_ZERO_OUT);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b1;
    in_state  = c_FIPS_IN;
    in_valid  = 1'b1;
    lat       = 0;
    do begin
      step();
      lat++;
      if (lat == 1) in_state = c_RAMP_IN;
    end while (!out_valid && lat < c_TMO);
    n_checks++;
    if (lat != 5 || out_state !== c_FIPS_OUT || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: lat=%0d in_ready=%b data=%h want 5/1/%h", lat, in_ready, out_state, c_FIPS_OUT);
    end
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_no_bubble: out_valid=%b busy=%b in_ready=%b want 0/1/0", out_valid, busy, in_ready);
    end
    lat = 1;
    while (!out_valid && lat < c_TMO) begin
      step();
      lat++;
    end
    n_checks++;
    if (lat != 5 || out_state !== c_RAMP_OUT) begin
      n_fail++;
      $display("FAIL b2b_second: lat=%0d data=%h want 5/%h", lat, out_state, c_RAMP_OUT);
    end
    step();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: out_valid=%b busy=%b want 0/0", out_valid, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    out_ready = 1'b0;
    in_state  = c_FIPS_IN;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_state !== 128'h0) begin
      n_fail++;
      $display("FAIL midrun_reset: out_valid=%b in_ready=%b busy=%b out_state=%h want 0/1/0/0",
               out_valid, in_ready, busy, out_state);
    end
    send_block(c_RAMP_IN, lat);
    n_checks++;
    if (lat != 5 || out_state !== c_RAMP_OUT) begin
      n_fail++;
      $display("FAIL midrun_recover: lat=%0d data=%h want 5/%h", lat, out_state, c_RAMP_OUT);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_all_bytes();
    int           lat;
    logic [127:0] v;
    logic [127:0] exp_v;
    out_ready = 1'b1;
    for (int b = 0; b < 16; b++) begin
      for (int i = 0; i < 16; i++) v[127-8*i -: 8] = 8'(b * 16 + i);
      exp_v = ref_sub(v);
      send_block(v, lat);
      n_checks++;
      if (out_state !== exp_v) begin
        n_fail++;
        $display("FAIL all_bytes_blk%0d: got %h want %h", b, out_state, exp_v);
      end
    end
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_state     = '0;
    out_ready    = 1'b0;
    ev_in_valid  = '0;
    ev_in_state  = '0;
    ev_out_ready = '0;

    test_reset();
    test_known_vector();
    test_ramp_params();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_all_bytes();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
